mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the mini-MIPS core: sequences fetch, decode, execute,
// memory and writeback one instruction at a time and drives the datapath strobes.
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        imem_rdy,
    input  logic        dmem_rdy,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_imm,
    output logic        hilo_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_ALUI, C_LOAD, C_STORE, C_BR, C_J, C_ACC, C_HALT, C_ILL
    } iclass_t;

    state_t  state, state_nxt;
    iclass_t iclass;
    logic    retire, set_illegal;

    always_comb begin
        iclass = C_ILL;
        case (opcode)
            6'h00:                                     iclass = C_R;
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: iclass = C_ALUI;
            6'h23:                                     iclass = C_LOAD;
            6'h2B:                                     iclass = C_STORE;
            6'h04, 6'h05, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17: iclass = C_BR;
            6'h02, 6'h03:                              iclass = C_J;
            6'h1C, 6'h1D:                              iclass = C_ACC;
            6'h3F:                                     iclass = C_HALT;
            default:                                   iclass = C_ILL;
        endcase
    end

    // Strobes are combinational so handshake responses (ir_we on imem_rdy) land in the same cycle.
    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_src_imm = 1'b0;
        hilo_we     = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wb_sel      = 2'd0;
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    pc_src    = 2'd0;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (iclass)
                    C_HALT: state_nxt = S_HALT;
                    C_ILL: begin
                        set_illegal = 1'b1;
                        state_nxt   = S_HALT;
                    end
                    C_J: begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                        if (opcode == 6'h03) begin
                            reg_we  = 1'b1;
                            reg_dst = 2'd2;
                            wb_sel  = 2'd2;
                        end
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_src_imm = (iclass == C_ALUI) || (iclass == C_LOAD) || (iclass == C_STORE);
                case (iclass)
                    C_R: begin
                        if (funct == 6'h08) begin
                            pc_we     = 1'b1;
                            pc_src    = 2'd3;
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                    C_BR: begin
                        pc_we     = branch_taken;
                        pc_src    = 2'd1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    C_ACC: begin
                        hilo_we   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    default:         state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_rd = (iclass == C_LOAD);
                dmem_wr = (iclass == C_STORE);
                if (dmem_rdy) begin
                    if (iclass == C_LOAD) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                reg_dst   = (iclass == C_R) ? 2'd0 : 2'd1;
                wb_sel    = (iclass == C_LOAD) ? 2'd1 : 2'd0;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_count <= 32'd0;
            illegal     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (retire)      instr_count <= instr_count + 32'd1;
            if (set_illegal) illegal     <= 1'b1;
        end
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-instruction expected cycle traces built from
// the instruction-class rules, checked every cycle, plus directed literal pins.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, imem_rdy, dmem_rdy, branch_taken;
    logic [5:0]  opcode, funct;
    logic        imem_req, ir_we, pc_we, alu_src_imm, hilo_we, reg_we;
    logic        dmem_rd, dmem_wr, busy, halted, illegal;
    logic [1:0]  pc_src, reg_dst, wb_sel;
    logic [31:0] instr_count;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .opcode(opcode), .funct(funct), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_imm(alu_src_imm), .hilo_we(hilo_we), .reg_we(reg_we), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .busy(busy),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       imem_req, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       alu_src_imm, hilo_we, reg_we;
        logic [1:0] reg_dst, wb_sel;
        logic       dmem_rd, dmem_wr, busy, halted;
        bit         in_exec;
    } exp_t;

    typedef enum int { K_R, K_ALUI, K_LOAD, K_STORE, K_BR, K_J, K_ACC, K_HALT, K_ILL } kind_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp;
    bit          exp_valid = 0;
    logic [31:0] exp_count;
    logic        exp_ill;
    logic [31:0] model_count;
    logic        model_ill;

    function automatic exp_t idle_e();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t active_e();
        exp_t e;
        e = '{default: '0};
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t halt_e();
        exp_t e;
        e = '{default: '0};
        e.halted = 1'b1;
        return e;
    endfunction

    function automatic kind_t classify(input logic [5:0] op);
        if (op == 6'h00) return K_R;
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return K_ALUI;
        if (op == 6'h23) return K_LOAD;
        if (op == 6'h2B) return K_STORE;
        if (op == 6'h04 || op == 6'h05 || (op >= 6'h12 && op <= 6'h17)) return K_BR;
        if (op == 6'h02 || op == 6'h03) return K_J;
        if (op == 6'h1C || op == 6'h1D) return K_ACC;
        if (op == 6'h3F) return K_HALT;
        return K_ILL;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Fields that are don't-care in a given cycle are zeroed on both sides before comparing.
    always @(negedge clk) begin
        if (exp_valid) begin
            logic [63:0] a, r;
            a = {15'b0, imem_req, ir_we, pc_we, exp.pc_we ? pc_src : 2'b0,
                 exp.in_exec ? alu_src_imm : 1'b0, hilo_we, reg_we,
                 exp.reg_we ? reg_dst : 2'b0, exp.reg_we ? wb_sel : 2'b0,
                 dmem_rd, dmem_wr, busy, halted, illegal, instr_count};
            r = {15'b0, exp.imem_req, exp.ir_we, exp.pc_we, exp.pc_we ? exp.pc_src : 2'b0,
                 exp.in_exec ? exp.alu_src_imm : 1'b0, exp.hilo_we, exp.reg_we,
                 exp.reg_we ? exp.reg_dst : 2'b0, exp.reg_we ? exp.wb_sel : 2'b0,
                 exp.dmem_rd, exp.dmem_wr, exp.busy, exp.halted, exp_ill, exp_count};
            checkOutput("cycle_outputs", a, r);
        end
    end

    task automatic applyStimulus(input logic st, input logic ir, input logic dr, input logic bt,
                                 input exp_t e, input bit ret, input bit set_ill, inout int ncyc);
        start        = st;
        imem_rdy     = ir;
        dmem_rdy     = dr;
        branch_taken = bt;
        exp          = e;
        exp_count    = model_count;
        exp_ill      = model_ill;
        exp_valid    = 1'b1;
        @(posedge clk);
        if (ret)     model_count = model_count + 32'd1;
        if (set_ill) model_ill   = 1'b1;
        ncyc++;
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic doReset();
        rst = 1'b1; start = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0; branch_taken = 1'b0;
        model_count = 32'd0;
        model_ill   = 1'b0;
        exp         = idle_e();
        exp_count   = 32'd0;
        exp_ill     = 1'b0;
        exp_valid   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // A few quiet IDLE cycles, then start together with imem_rdy, which must only move to FETCH.
    task automatic idleStart(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, rb(), rb(), rb(), idle_e(), 0, 0, c);
        applyStimulus(1'b1, 1'b1, rb(), rb(), idle_e(), 0, 0, c);
    endtask

    task automatic haltCycles(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) applyStimulus(rb(), rb(), rb(), rb(), halt_e(), 0, 0, c);
    endtask

    // Expected trace of one instruction, from FETCH until it retires or reaches HALT.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                            input logic bt, input bit abort_mem, output int ncyc);
        exp_t  e;
        kind_t k;
        ncyc   = 0;
        opcode = op;
        funct  = fn;
        k      = classify(op);
        for (int i = 0; i < fw; i++) begin
            e = active_e(); e.imem_req = 1'b1;
            applyStimulus(rb(), 1'b0, rb(), rb(), e, 0, 0, ncyc);
        end
        e = active_e(); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd0;
        applyStimulus(rb(), 1'b1, rb(), rb(), e, 0, 0, ncyc);

        e = active_e();
        if (k == K_HALT || k == K_ILL) begin
            applyStimulus(rb(), rb(), rb(), rb(), e, 0, k == K_ILL, ncyc);
            return;
        end
        if (k == K_J) begin
            e.pc_we = 1'b1; e.pc_src = 2'd2;
            if (op == 6'h03) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2; end
            applyStimulus(rb(), rb(), rb(), rb(), e, 1, 0, ncyc);
            return;
        end
        applyStimulus(rb(), rb(), rb(), rb(), e, 0, 0, ncyc);

        e = active_e(); e.in_exec = 1'b1;
        e.alu_src_imm = (k == K_ALUI || k == K_LOAD || k == K_STORE);
        if ((k == K_R && fn == 6'h08) || k == K_BR || k == K_ACC) begin
            if (k == K_R)  begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
            if (k == K_BR) begin e.pc_we = bt;   e.pc_src = 2'd1; end
            if (k == K_ACC) e.hilo_we = 1'b1;
            applyStimulus(rb(), rb(), rb(), bt, e, 1, 0, ncyc);
            return;
        end
        applyStimulus(rb(), rb(), rb(), rb(), e, 0, 0, ncyc);

        if (k == K_LOAD || k == K_STORE) begin
            e = active_e(); e.dmem_rd = (k == K_LOAD); e.dmem_wr = (k == K_STORE);
            if (abort_mem) begin
                start = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
                exp = e; exp_count = model_count; exp_ill = model_ill; exp_valid = 1'b1;
                #1;
                checkOutput("mem_strobe_before_rst", {63'b0, dmem_wr}, 64'd1);
                rst = 1'b1;
                model_count = 32'd0; model_ill = 1'b0;
                exp = idle_e(); exp_count = 32'd0; exp_ill = 1'b0;
                #1;
                checkOutput("dmem_wr_at_rst", {63'b0, dmem_wr}, 64'd0);
                checkOutput("count_at_rst", {32'b0, instr_count}, 64'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            for (int i = 0; i < mw; i++) applyStimulus(rb(), rb(), 1'b0, rb(), e, 0, 0, ncyc);
            applyStimulus(rb(), rb(), 1'b1, rb(), e, k == K_STORE, 0, ncyc);
            if (k == K_STORE) return;
        end

        e = active_e(); e.reg_we = 1'b1;
        e.reg_dst = (k == K_R) ? 2'd0 : 2'd1;
        e.wb_sel  = (k == K_LOAD) ? 2'd1 : 2'd0;
        applyStimulus(rb(), rb(), rb(), rb(), e, 1, 0, ncyc);
    endtask

    logic [5:0] legal_ops [0:22] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                     6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h12, 6'h13, 6'h14,
                                     6'h15, 6'h16, 6'h17, 6'h02, 6'h03, 6'h1C, 6'h1D};
    logic [5:0] functs [0:4] = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h2A};

    initial begin
        int n;
        logic [5:0] op, fn;
        opcode = 6'h00; funct = 6'h00;
        doReset();
        checkOutput("reset_state", {32'b0, instr_count, busy, halted, illegal, imem_req},
                    64'h0);

        idleStart(2);
        runInstr(6'h00, 6'h20, 0, 0, 1'b0, 0, n);
        checkOutput("add_cycles", 64'(n), 64'd4);
        checkOutput("count_after_add", {32'b0, instr_count}, 64'd1);

        runInstr(6'h23, 6'h00, 0, 3, 1'b0, 0, n);
        checkOutput("load_wait_cycles", 64'(n), 64'd8);
        runInstr(6'h04, 6'h00, 0, 0, 1'b0, 0, n);
        checkOutput("beq_cycles", 64'(n), 64'd3);
        runInstr(6'h05, 6'h00, 0, 0, 1'b1, 0, n);
        checkOutput("bne_cycles", 64'(n), 64'd3);
        runInstr(6'h03, 6'h00, 0, 0, 1'b0, 0, n);
        checkOutput("jal_cycles", 64'(n), 64'd2);
        runInstr(6'h2B, 6'h00, 0, 0, 1'b0, 0, n);
        checkOutput("store_cycles", 64'(n), 64'd4);
        runInstr(6'h0D, 6'h00, 2, 0, 1'b0, 0, n);
        checkOutput("ori_fetch_wait_cycles", 64'(n), 64'd6);
        checkOutput("count_after_seq", {32'b0, instr_count}, 64'd7);

        runInstr(6'h2B, 6'h00, 0, 0, 1'b0, 1, n);
        idleStart(1);
        runInstr(6'h00, 6'h2A, 1, 0, 1'b0, 0, n);
        checkOutput("count_after_rst_restart", {32'b0, instr_count}, 64'd1);

        runInstr(6'h3F, 6'h00, 0, 0, 1'b0, 0, n);
        haltCycles(4);
        checkOutput("halt_flags", {60'b0, halted, illegal, busy, 1'b0}, 64'b1000);
        checkOutput("halt_no_retire", {32'b0, instr_count}, 64'd1);

        doReset();
        idleStart(0);
        runInstr(6'h3E, 6'h00, 0, 0, 1'b0, 0, n);
        haltCycles(4);
        checkOutput("illegal_flags", {60'b0, halted, illegal, busy, 1'b0}, 64'b1100);
        checkOutput("illegal_no_retire", {32'b0, instr_count}, 64'd0);

        doReset();
        idleStart(1);
        for (int t = 0; t < 150; t++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                op = 6'h3F;
            end else if (r < 8) begin
                op = 6'($urandom_range(0, 63));
                while (classify(op) != K_ILL) op = 6'($urandom_range(0, 63));
            end else begin
                op = legal_ops[$urandom_range(0, 22)];
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
            runInstr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 0, n);
            if (classify(op) == K_HALT || classify(op) == K_ILL) begin
                haltCycles(2);
                doReset();
                idleStart($urandom_range(0, 2));
            end
        end

        exp_valid = 1'b0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
